// File: rtl/mem_rmw_pkg.sv
// Shared types and sizing for the masked-write RMW controller.
// Pure declarations: no logic, no latency.
// Optional build macro MEM_RMW_FULL_SKIP_EN is consumed by mem_1r1w_rmw_ctrl.
package mem_rmw_pkg;

  localparam int DEPTH     = 48;
  localparam int ADDR_W    = 6;
  localparam int DATA_W    = 64;
  localparam int MASK_GRAN = 8;
  localparam int MASK_W    = DATA_W / MASK_GRAN;

  // Kind of operation travelling down the two-stage pipeline
  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  // Which requester won the most recent grant
  typedef enum logic {
    READ_LAST  = 1'b0,
    WRITE_LAST = 1'b1
  } grant_e;

  // Widen a per-lane mask into a per-bit mask
  function automatic logic [DATA_W-1:0] expand_mask(input logic [MASK_W-1:0] m);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < MASK_W; i++) begin
      r[i*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{m[i]}};
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_rmw_merge.sv
// Lane merge: picks forwarded or memory "old" word, overlays masked new lanes.
// Latency: purely combinational.
// Backpressure: none (no handshake).
module mem_rmw_merge
  import mem_rmw_pkg::*;
(
  input  logic [DATA_W-1:0] old_dat,
  input  logic [DATA_W-1:0] new_dat,
  input  logic [MASK_W-1:0] mask,
  input  logic              fwd_hit,
  input  logic [DATA_W-1:0] fwd_dat,
  output logic [DATA_W-1:0] merged_dat
);

  logic [DATA_W-1:0] base_dat;
  logic [DATA_W-1:0] bit_mask;

  // Forwarded data replaces the stale memory word when the previous write hit this address
  always_comb begin
    base_dat   = fwd_hit ? fwd_dat : old_dat;
    bit_mask   = expand_mask(mask);
    merged_dat = (base_dat & ~bit_mask) | (new_dat & bit_mask);
  end

endmodule

// File: rtl/mem_1r1w_rmw_ctrl.sv
// Masked-write to read-modify-write controller in front of an unmasked 1R1W SRAM.
// Latency: R0 issued in the accept cycle, read response / W0 write one cycle later.
// Backpressure: read/write requests alternate on a shared R0 slot; responses cannot stall.
// Build option: MEM_RMW_FULL_SKIP_EN skips the memory read for all-ones write masks.
module mem_1r1w_rmw_ctrl
  import mem_rmw_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [MASK_W-1:0] wr_mask,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_resp_valid,
  output logic [DATA_W-1:0] rd_resp_data,
  output logic [ADDR_W-1:0] R0_addr,
  output logic              R0_en,
  input  logic [DATA_W-1:0] R0_data,
  output logic [ADDR_W-1:0] W0_addr,
  output logic              W0_en,
  output logic [DATA_W-1:0] W0_data
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  grant_e            last_grant_q, last_grant_d;
  logic              s2_vld_q, s2_vld_d;
  op_e               s2_op_q, s2_op_d;
  logic              s2_oor_q, s2_oor_d;
  logic [ADDR_W-1:0] s2_addr_q, s2_addr_d;
  logic [DATA_W-1:0] s2_data_q, s2_data_d;
  logic [MASK_W-1:0] s2_mask_q, s2_mask_d;
  logic              s2_fwd_hit_q, s2_fwd_hit_d;
  logic [DATA_W-1:0] s2_fwd_dat_q, s2_fwd_dat_d;
  logic [DATA_W-1:0] rd_hold_q, rd_hold_d;

  logic              wr_gnt, rd_gnt;
  logic              wr_in_range, rd_in_range;
  logic              s1_wr_live, s1_rd_mem, s1_full;
  logic [DATA_W-1:0] merged_dat;

  // Arbitration: lone requester wins, ties alternate starting with the write
  always_comb begin
    wr_gnt       = wr_valid && (!rd_valid || (last_grant_q == READ_LAST));
    rd_gnt       = rd_valid && (!wr_valid || (last_grant_q == WRITE_LAST));
    wr_ready     = wr_gnt;
    rd_ready     = rd_gnt;
    last_grant_d = last_grant_q;
    if (wr_gnt) begin
      last_grant_d = WRITE_LAST;
    end else if (rd_gnt) begin
      last_grant_d = READ_LAST;
    end
  end

  // Stage 1: decide memory read issue, capture forwarding from the write leaving stage 2
  always_comb begin
    wr_in_range  = (wr_addr < DEPTH_A);
    rd_in_range  = (rd_addr < DEPTH_A);
    s1_wr_live   = wr_gnt && wr_in_range && (|wr_mask);
    s1_rd_mem    = rd_gnt && rd_in_range;
`ifdef MEM_RMW_FULL_SKIP_EN
    s1_full      = &wr_mask;
`else
    s1_full      = 1'b0;
`endif
    R0_en        = s1_rd_mem || (s1_wr_live && !s1_full);
    R0_addr      = wr_gnt ? wr_addr : rd_addr;
    s2_fwd_hit_d = R0_en && W0_en && (W0_addr == R0_addr);
    s2_fwd_dat_d = W0_data;
    s2_vld_d     = rd_gnt || s1_wr_live;
    s2_op_d      = wr_gnt ? OP_WR : OP_RD;
    s2_oor_d     = rd_gnt && !rd_in_range;
    s2_addr_d    = R0_addr;
    s2_data_d    = wr_data;
    s2_mask_d    = wr_gnt ? wr_mask : '0;
  end

  // Reads pass a zero mask through the merge so they see the (possibly forwarded) old word
  mem_rmw_merge u_merge (
    .old_dat    (R0_data),
    .new_dat    (s2_data_q),
    .mask       (s2_mask_q),
    .fwd_hit    (s2_fwd_hit_q),
    .fwd_dat    (s2_fwd_dat_q),
    .merged_dat (merged_dat)
  );

  // Stage 2: write back merged word or return read data; response data holds between reads
  always_comb begin
    W0_en         = s2_vld_q && (s2_op_q == OP_WR);
    W0_addr       = s2_addr_q;
    W0_data       = merged_dat;
    rd_resp_valid = s2_vld_q && (s2_op_q == OP_RD);
    if (rd_resp_valid) begin
      rd_resp_data = s2_oor_q ? '0 : merged_dat;
    end else begin
      rd_resp_data = rd_hold_q;
    end
    rd_hold_d = rd_resp_data;
  end

  // Pipeline and arbitration state; reset discards any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= READ_LAST;
      s2_vld_q     <= 1'b0;
      s2_op_q      <= OP_RD;
      s2_oor_q     <= 1'b0;
      s2_addr_q    <= '0;
      s2_data_q    <= '0;
      s2_mask_q    <= '0;
      s2_fwd_hit_q <= 1'b0;
      s2_fwd_dat_q <= '0;
      rd_hold_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      s2_vld_q     <= s2_vld_d;
      s2_op_q      <= s2_op_d;
      s2_oor_q     <= s2_oor_d;
      s2_addr_q    <= s2_addr_d;
      s2_data_q    <= s2_data_d;
      s2_mask_q    <= s2_mask_d;
      s2_fwd_hit_q <= s2_fwd_hit_d;
      s2_fwd_dat_q <= s2_fwd_dat_d;
      rd_hold_q    <= rd_hold_d;
    end
  end

endmodule
